// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - assembles 4-byte UART command frames into register writes
//
// Purpose:
//   Takes bytes from the UART receiver over a valid/ack handshake, builds
//   header/address/data/checksum frames and issues one write strobe per
//   verified frame. Malformed frames, receiver errors and inter-byte timeouts
//   pulse frame_err and bump a saturating error counter.
//
// Ports:
//   clk        in   master clock
//   rst        in   synchronous reset, active high
//   rx_data    in   [7:0] received byte, valid while rx_valid=1
//   rx_valid   in   receiver byte available, held until acked
//   rx_error   in   receiver parity/overrun error, held until acked
//   rx_ack     out  one-cycle acknowledge to the receiver
//   wr_en      out  one-cycle register write strobe
//   wr_addr    out  [7:0] write address, held between writes
//   wr_data    out  [7:0] write data, held between writes
//   frame_err  out  one-cycle pulse on any frame failure
//   err_count  out  [C_ERRCNT_WIDTH-1:0] saturating frame-failure count
//   busy       out  high while a frame is partially received

module uart_cmd_parser #(
    parameter logic [7:0] C_HEADER       = 8'hA5,
    parameter int          C_TIMEOUT      = 100000,
    parameter int          C_ACK_HOLDOFF  = 2,
    parameter int          C_ERRCNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    input  logic                      rx_error,
    output logic                      rx_ack,
    output logic                      wr_en,
    output logic [7:0]                wr_addr,
    output logic [7:0]                wr_data,
    output logic                      frame_err,
    output logic [C_ERRCNT_WIDTH-1:0] err_count,
    output logic                      busy
);

    localparam int TW = $clog2(C_TIMEOUT + 1);
    localparam int HW = $clog2(C_ACK_HOLDOFF + 2);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(C_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLDOFF_LOAD = HW'(C_ACK_HOLDOFF);

    typedef enum logic [1:0] {
        sHDR,
        sADDR,
        sDATA,
        sCHK
    } stateType;

    stateType                  state, stateNext;
    logic [HW-1:0]             holdoff, holdoffNext;
    logic [TW-1:0]             toutCnt, toutNext;
    logic [7:0]                addrReg, addrNext;
    logic [7:0]                dataReg, dataNext;
    logic                      ackNext;
    logic                      wrEnNext;
    logic [7:0]                wrAddrNext, wrDataNext;
    logic                      frameErrNext;
    logic [C_ERRCNT_WIDTH-1:0] errCountNext;
    logic                      accept;
    logic                      failNow;

    // The receiver needs a few cycles to drop its flags after seeing the ack,
    // so nothing is taken while the holdoff counter is running.
    assign accept = (rx_valid || rx_error) && (holdoff == '0);

    always_comb begin
        stateNext    = state;
        addrNext     = addrReg;
        dataNext     = dataReg;
        wrEnNext     = 1'b0;
        wrAddrNext   = wr_addr;
        wrDataNext   = wr_data;
        failNow      = 1'b0;
        ackNext      = accept;

        if (accept) begin
            holdoffNext = HOLDOFF_LOAD;
        end else if (holdoff != '0) begin
            holdoffNext = holdoff - 1'b1;
        end else begin
            holdoffNext = '0;
        end

        if (accept) begin
            // A receiver error outranks any byte that came with it.
            if (rx_error) begin
                failNow   = 1'b1;
                stateNext = sHDR;
            end else begin
                unique case (state)
                    sHDR: begin
                        // Anything other than the header is silently dropped.
                        if (rx_data == C_HEADER) begin
                            stateNext = sADDR;
                        end
                    end
                    sADDR: begin
                        addrNext  = rx_data;
                        stateNext = sDATA;
                    end
                    sDATA: begin
                        dataNext  = rx_data;
                        stateNext = sCHK;
                    end
                    sCHK: begin
                        if (rx_data == (C_HEADER ^ addrReg ^ dataReg)) begin
                            wrEnNext   = 1'b1;
                            wrAddrNext = addrReg;
                            wrDataNext = dataReg;
                        end else begin
                            failNow = 1'b1;
                        end
                        stateNext = sHDR;
                    end
                endcase
            end
        end else if ((state != sHDR) && (toutCnt == TIMEOUT_LAST)) begin
            failNow   = 1'b1;
            stateNext = sHDR;
        end

        // The inter-byte timer only runs while a frame is in progress.
        if (accept || (stateNext == sHDR)) begin
            toutNext = '0;
        end else begin
            toutNext = toutCnt + 1'b1;
        end

        frameErrNext = failNow;
        if (failNow && (err_count != '1)) begin
            errCountNext = err_count + 1'b1;
        end else begin
            errCountNext = err_count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= sHDR;
            holdoff   <= '0;
            toutCnt   <= '0;
            addrReg   <= '0;
            dataReg   <= '0;
            rx_ack    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            err_count <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            holdoff   <= holdoffNext;
            toutCnt   <= toutNext;
            addrReg   <= addrNext;
            dataReg   <= dataNext;
            rx_ack    <= ackNext;
            wr_en     <= wrEnNext;
            wr_addr   <= wrAddrNext;
            wr_data   <= wrDataNext;
            frame_err <= frameErrNext;
            err_count <= errCountNext;
            busy      <= (stateNext != sHDR);
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - scoreboard bench for uart_cmd_parser

module tb_uart_cmd_parser;

    localparam logic [7:0] HDR  = 8'hA5;
    localparam int         TOUT = 50;
    localparam int         HOLD = 2;
    localparam int         EW   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_error;
    logic          rx_ack;
    logic          wr_en;
    logic [7:0]    wr_addr;
    logic [7:0]    wr_data;
    logic          frame_err;
    logic [EW-1:0] err_count;
    logic          busy;

    uart_cmd_parser #(
        .C_HEADER      (HDR),
        .C_TIMEOUT     (TOUT),
        .C_ACK_HOLDOFF (HOLD),
        .C_ERRCNT_WIDTH(EW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_error (rx_error),
        .rx_ack   (rx_ack),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frame_err(frame_err),
        .err_count(err_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         isWrite;
        logic [7:0] addr;
        logic [7:0] data;
        int         errCnt;
        bit         withAck;
    } expEvent;

    expEvent    expQ[$];
    logic [7:0] frameQ[$];
    expEvent    monEv;
    int         modelErr = 0;
    int         bytesSent = 0;
    int         acksSeen = 0;
    int         checks = 0;
    int         failures = 0;
    int         cycle = 0;
    int         lastAckCycle = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: works on whole byte sequences, not cycles.
    function automatic void noteFail(bit withAck);
        expEvent e;
        modelErr  = (modelErr < 255) ? modelErr + 1 : 255;
        e.isWrite = 1'b0;
        e.addr    = 8'h00;
        e.data    = 8'h00;
        e.errCnt  = modelErr;
        e.withAck = withAck;
        expQ.push_back(e);
    endfunction

    function automatic void modelByte(logic [7:0] b, bit err);
        expEvent e;
        if (err) begin
            frameQ.delete();
            noteFail(1'b1);
        end else if (frameQ.size() == 0) begin
            if (b == HDR) frameQ.push_back(b);
        end else begin
            frameQ.push_back(b);
            if (frameQ.size() == 4) begin
                if ((frameQ[0] ^ frameQ[1] ^ frameQ[2]) == frameQ[3]) begin
                    e.isWrite = 1'b1;
                    e.addr    = frameQ[1];
                    e.data    = frameQ[2];
                    e.errCnt  = modelErr;
                    e.withAck = 1'b1;
                    expQ.push_back(e);
                end else begin
                    noteFail(1'b1);
                end
                frameQ.delete();
            end
        end
    endfunction

    function automatic void modelTimeout();
        if (frameQ.size() != 0) begin
            frameQ.delete();
            noteFail(1'b0);
        end
    endfunction

    function automatic void modelReset();
        check("queue_empty_at_reset", expQ.size(), 0);
        expQ.delete();
        frameQ.delete();
        modelErr = 0;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT reports a frame outcome.
    always @(negedge clk) begin
        cycle++;
        if (rx_ack) acksSeen++;
        if (wr_en && frame_err) begin
            failures++;
            $display("FAIL wr_fe_exclusive: wr_en=1 frame_err=1 at cycle %0d", cycle);
        end
        if (wr_en || frame_err) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: wr_en=%0b frame_err=%0b expected none", wr_en, frame_err);
            end else begin
                monEv = expQ.pop_front();
                check("event_kind", wr_en, monEv.isWrite);
                if (monEv.isWrite) begin
                    check("wr_addr", wr_addr, monEv.addr);
                    check("wr_data", wr_data, monEv.data);
                end
                check("err_count_at_event", err_count, monEv.errCnt);
                check("ack_with_event", rx_ack, monEv.withAck);
                if (!monEv.withAck) check("timeout_latency", cycle - lastAckCycle, TOUT);
            end
        end
        if (rx_ack) lastAckCycle = cycle;
    end

    task automatic sendByte(input logic [7:0] b, input bit err, input bit bothHigh,
                            input int stale, input int gap, input bit withRst);
        bit got;
        int n;
        if (withRst) begin
            rst = 1'b1;
            modelReset();
        end
        modelByte(b, err);
        rx_data  = b;
        rx_error = err;
        rx_valid = !err || bothHigh;
        bytesSent++;
        if (withRst) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        got = 1'b0;
        n = 0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            got = rx_ack;
        end
        check("ack_arrives", got, 1);
        // Model a receiver that is slow to drop its flags after the ack.
        repeat (stale) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendFrame(input logic [7:0] a, input logic [7:0] d, input bit good,
                             input int stale, input bit randTiming);
        logic [7:0] chk;
        chk = HDR ^ a ^ d;
        if (!good) chk = chk ^ 8'($urandom_range(1, 255));
        sendByte(HDR, 0, 0, randTiming ? $urandom_range(0, 2) : stale, randTiming ? $urandom_range(0, 3) : 0, 0);
        sendByte(a,   0, 0, randTiming ? $urandom_range(0, 2) : stale, randTiming ? $urandom_range(0, 3) : 0, 0);
        sendByte(d,   0, 0, randTiming ? $urandom_range(0, 2) : stale, randTiming ? $urandom_range(0, 3) : 0, 0);
        sendByte(chk, 0, 0, randTiming ? $urandom_range(0, 2) : stale, randTiming ? $urandom_range(0, 3) : 0, 0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("busy_after_reset", busy, 0);
        check("err_count_after_reset", err_count, modelErr);
        check("wr_addr_after_reset", wr_addr, 0);
        check("wr_data_after_reset", wr_data, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, d, j;
        int nJunk;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_ack", rx_ack, 0);
        check("reset_wr_en", wr_en, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_wr_data", wr_data, 0);
        check("reset_err_count", err_count, 0);
        rst = 1'b0;

        // Good frame, then bad checksum.
        sendFrame(8'h10, 8'h3C, 1, 0, 0);
        check("err_count_good", err_count, 0);
        sendByte(HDR,   0, 0, 0, 0, 0);
        sendByte(8'h10, 0, 0, 0, 0, 0);
        sendByte(8'h3C, 0, 0, 0, 0, 0);
        sendByte(8'h88, 0, 0, 0, 2, 0);
        check("busy_after_bad", busy, 0);
        check("err_count_bad", err_count, modelErr);

        // Junk before the header.
        sendByte(8'h00, 0, 0, 0, 0, 0);
        sendByte(8'hFF, 0, 0, 0, 0, 0);
        sendByte(HDR,   0, 0, 0, 0, 0);
        sendByte(8'h01, 0, 0, 0, 0, 0);
        sendByte(8'h02, 0, 0, 0, 0, 0);
        sendByte(8'hA6, 0, 0, 0, 0, 0);

        // Slow receiver flag release.
        sendFrame(8'h11, 8'h22, 1, 2, 0);

        // Inter-byte timeout, then recovery.
        sendByte(HDR,   0, 0, 0, 0, 0);
        sendByte(8'h10, 0, 0, 0, 0, 0);
        check("busy_mid_frame", busy, 1);
        modelTimeout();
        repeat (TOUT + 10) @(posedge clk);
        #1;
        check("busy_after_timeout", busy, 0);
        sendFrame(8'h44, 8'h55, 1, 1, 0);

        // Receiver error mid-frame, then reset mid-frame during holdoff.
        doReset();
        sendByte(HDR,   0, 0, 0, 0, 0);
        sendByte(8'h00, 1, 1, 0, 0, 0);
        check("err_count_rx_error", err_count, 1);
        sendByte(HDR,   0, 0, 0, 0, 0);
        sendByte(8'h20, 0, 0, 0, 0, 0);
        doReset();

        // Byte pending across reset is treated as a fresh header.
        sendByte(HDR,   0, 0, 0, 0, 1);
        sendByte(8'h01, 0, 0, 0, 0, 0);
        sendByte(8'h02, 0, 0, 0, 0, 0);
        sendByte(8'hA6, 0, 0, 0, 0, 0);

        // Randomized frames with junk, errors and variable timing.
        for (int i = 0; i < 40; i++) begin
            nJunk = $urandom_range(0, 2);
            for (int k = 0; k < nJunk; k++) begin
                j = 8'($urandom);
                if (j == HDR) j = 8'h00;
                sendByte(j, 0, 0, $urandom_range(0, 2), $urandom_range(0, 3), 0);
            end
            a = 8'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                sendByte(HDR, 0, 0, $urandom_range(0, 2), $urandom_range(0, 3), 0);
                sendByte(8'($urandom), 1, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3), 0);
            end else begin
                sendFrame(a, d, $urandom_range(0, 3) != 0, 0, 1);
            end
        end
        check("err_count_random", err_count, modelErr);

        // Saturation of the error counter.
        doReset();
        for (int i = 0; i < 300; i++) begin
            sendFrame(8'($urandom), 8'($urandom), 0, 0, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("err_count_saturated", err_count, 255);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", expQ.size(), 0);
        check("ack_total", acksSeen, bytesSent);
        check("busy_final", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
